multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the 16-bit core.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Produces the 2-bit alu_op consumed by the ALU-control decoder (00 = R-type/decode by opcode, 01 = address add, 10 = branch subtract), plus all datapath enables.
- Drives a single-port memory through a req/ready handshake with a wait-limit watchdog.

Parameters:
WAIT_LIMIT, 15, max cycles mem_req may wait for mem_ready before bus error (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_rdata_op  in  4  opcode field of memory read data, valid with mem_ready during fetch
mem_ready  in  1  memory completes current request
zero  in  1  ALU zero flag, valid in EXEC
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write strobe (STORE in MEM only)
iord  out  1  0 = address from PC, 1 = address from ALU result
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  2  00 = PC+2, 01 = branch target, 10 = jump target
alu_op  out  2  ALU class to ALU-control decoder
alu_src_b  out  1  0 = register, 1 = sign-extended immediate
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory
halted  out  1  core stopped (HALT or bus error)
bus_error  out  1  sticky, watchdog expired
illegal_op  out  1  one-cycle pulse on unknown opcode
retired  out  CNT_W  instructions completed, wraps at 2^CNT_W

Behaviour:
- Opcode map: 0000 LOAD, 0001 STORE, 0010 ADD, 0011 ADDI, 0100 SUB, 0101 NOT, 0110 SHL, 0111 SHR, 1000 AND, 1001 OR, 1010 BEQ, 1011 BNE, 1100 JMP, 1111 HALT. Opcodes 1101 and 1110 are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs: combinational from state, the latched opcode, zero and mem_ready.
- Unlisted outputs are 0 in every state.
- Reset (asynchronous, takes effect mid-operation): state = IDLE, opcode reg = 0, wait counter = 0, retired = 0, bus_error = 0. All outputs read 0, so mem_req drops immediately. IDLE lasts one cycle, then goes to FETCH.
- FETCH: mem_req = 1, iord = 0.
  - If mem_ready: ir_write = 1, pc_write = 1, pc_src = 00; latch mem_rdata_op; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_op = 00, one cycle.
  - JMP: pc_write = 1, pc_src = 10; retire; go to FETCH.
  - HALT: retire; go to HALT.
  - Illegal opcode: illegal_op = 1; no retire; go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC:
  - R-type (0010..1001): alu_op = 00; alu_src_b = 1 for ADDI only; go to WB.
  - LOAD/STORE: alu_op = 01, alu_src_b = 1; go to MEM.
  - BEQ/BNE: alu_op = 10, alu_src_b = 0. pc_write = zero (BEQ) or ~zero (BNE), pc_src = 01. Retire; go to FETCH.
- MEM: mem_req = 1, iord = 1, mem_we = (STORE), alu_op = 01, alu_src_b = 1. Wait for mem_ready.
  - STORE: retire; go to FETCH.
  - LOAD: go to WB.
- WB: reg_write = 1, mem_to_reg = (LOAD). Retire; go to FETCH.
- HALT: halted = 1, absorbing until reset.
- Latency, assuming zero-wait memory: R-type 4 cycles, LOAD 5, STORE 4, branch 3, JMP 2.
- Handshake:
  - mem_req and iord stay stable until the mem_ready cycle.
  - mem_ready outside FETCH/MEM is ignored.
  - mem_ready in the first request cycle completes with zero wait.
- Watchdog:
  - The counter increments each FETCH/MEM cycle with mem_req = 1 and mem_ready = 0.
  - It clears on completion.
  - When it reaches WAIT_LIMIT without mem_ready: bus_error = 1 (sticky), go to HALT, mem_req drops.
  - mem_ready in the same cycle the counter hits the limit wins: the request completes.
- Retire: retired increments by 1 at the retire point above, modulo 2^CNT_W.

Test Plan:
- Reset release, zero-wait memory, ADD (0010) -> IDLE 1 cycle; FETCH/DECODE/EXEC/WB with alu_op 00,00,00; reg_write pulses once in WB; retired = 1.
- LOAD with mem_ready delayed 3 cycles in MEM -> mem_req, iord = 1 held 4 cycles; then WB with mem_to_reg = 1; total 8 cycles; alu_op = 01 in EXEC/MEM.
- BEQ with zero = 1, then BNE with zero = 1 -> first: pc_write = 1, pc_src = 01 in EXEC; second: pc_write = 0; retired += 2.
- Opcode 1101 -> illegal_op pulses one cycle in DECODE, back to FETCH, retired unchanged; then HALT (1111) -> halted = 1 stays.
- WAIT_LIMIT = 15, mem_ready never asserted in FETCH -> after 15 wait cycles bus_error = 1, halted = 1, mem_req = 0; variant with mem_ready on the 15th cycle completes normally.
- rst_n low mid-MEM of a STORE -> mem_req and mem_we drop asynchronously, retired = 0, restart via IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the 16-bit core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the memory
// req/ready handshake with a wait-limit watchdog and counts retired instructions.
module multicycle_main_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       mem_rdata_op,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src_b,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             bus_error,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_BNE   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Last wait cycle index: a request still unanswered here times out.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       opcode;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic             bus_err_q;

    logic is_rtype, is_mem_op, is_branch, is_illegal;
    logic waiting, timeout, retire;

    assign is_rtype   = (opcode >= 4'h2) && (opcode <= 4'h9);
    assign is_mem_op  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_illegal = (opcode == 4'hD) || (opcode == 4'hE);

    // A request is outstanding whenever we sit in FETCH/MEM without ready;
    // ready arriving on the last allowed cycle still completes.
    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timeout = waiting && (wait_cnt == WAIT_LAST);

    // Retire point for each instruction class.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_DECODE: retire = (opcode == OP_JMP) || (opcode == OP_HALT);
            S_EXEC:   retire = is_branch;
            S_MEM:    retire = mem_ready && (opcode == OP_STORE);
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_HALT;
            end
            S_DECODE: begin
                if (opcode == OP_HALT)                    state_nxt = S_HALT;
                else if ((opcode == OP_JMP) || is_illegal) state_nxt = S_FETCH;
                else                                       state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch)      state_nxt = S_FETCH;
                else if (is_mem_op) state_nxt = S_MEM;
                else                state_nxt = S_WB;
            end
            S_MEM: begin
                if (mem_ready)      state_nxt = (opcode == OP_STORE) ? S_FETCH : S_WB;
                else if (timeout)   state_nxt = S_HALT;
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Opcode latch, watchdog counter, sticky bus error and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode     <= 4'h0;
            wait_cnt   <= 8'd0;
            retire_cnt <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            if ((state == S_FETCH) && mem_ready) opcode <= mem_rdata_op;
            if (waiting) wait_cnt <= wait_cnt + 8'd1;
            else         wait_cnt <= 8'd0;
            if (timeout) bus_err_q <= 1'b1;
            if (retire)  retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Datapath controls, decoded from state, latched opcode, zero and ready.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        alu_src_b  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                if (opcode == OP_JMP) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                illegal_op = is_illegal;
            end
            S_EXEC: begin
                if (is_mem_op) begin
                    alu_op    = 2'b01;
                    alu_src_b = 1'b1;
                end else if (is_branch) begin
                    alu_op   = 2'b10;
                    pc_src   = 2'b01;
                    pc_write = (opcode == OP_BEQ) ? zero : !zero;
                end else if (is_rtype) begin
                    alu_src_b = (opcode == OP_ADDI);
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_we    = (opcode == OP_STORE);
                alu_op    = 2'b01;
                alu_src_b = 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD);
            end
            default: ;
        endcase
    end

    assign halted    = (state == S_HALT);
    assign bus_error = bus_err_q;
    assign retired   = retire_cnt;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: latency/enable table, randomized
// instruction stream against a per-instruction phase model, and directed
// watchdog / reset corner cases.
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mem_rdata_op = 4'h0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src, alu_op;
    logic        alu_src_b, reg_write, mem_to_reg, halted, bus_error, illegal_op;
    logic [15:0] retired;

    multicycle_main_control #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata_op(mem_rdata_op),
        .mem_ready(mem_ready), .zero(zero), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .halted(halted), .bus_error(bus_error),
        .illegal_op(illegal_op), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write;
        logic [1:0] pc_src, alu_op;
        logic       alu_src_b, reg_write, mem_to_reg, halted, bus_error, illegal_op;
    } ctl_t;

    ctl_t act;
    assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_op,
                  alu_src_b, reg_write, mem_to_reg, halted, bus_error, illegal_op};

    typedef struct {
        logic [3:0] op;
        logic       z;
        int         lat;
        int         regw;
        int         pcw;
        int         dret;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int ret_m  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    // One clock: drive inputs, compare all controls mid-cycle, step past the edge.
    task automatic cyc(input logic rdy, input logic [3:0] op, input logic z,
                       input ctl_t exp, input string name);
        mem_ready    = rdy;
        mem_rdata_op = op;
        zero         = z;
        @(negedge clk);
        chk(name, 32'(act), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'(act), 32'(ctl_t'('0)));
        chk("rst_retired", 32'(retired), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ret_m = 0;
        cyc(rnd1(), rop(), rnd1(), ctl_t'('0), "idle");
    endtask

    // Expected behaviour of one instruction, expanded phase by phase from the
    // opcode class; fw/mw are wait cycles before ready in FETCH/MEM.
    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        ctl_t e;
        bit   is_r  = (op >= 4'h2) && (op <= 4'h9);
        bit   is_ls = (op <= 4'h1);
        bit   is_br = (op == 4'hA) || (op == 4'hB);
        bit   ill   = (op == 4'hD) || (op == 4'hE);
        chk("retired", 32'(retired), 32'(16'(ret_m)));
        for (int i = 0; i <= fw; i++) begin
            e = '0;
            e.mem_req = 1'b1;
            if (i == fw) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            cyc(i == fw, (i == fw) ? op : rop(), rnd1(), e, "fetch");
        end
        e = '0;
        if (op == 4'hC) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'b10;
        end
        e.illegal_op = ill;
        cyc(rnd1(), rop(), rnd1(), e, "decode");
        if (op == 4'hC) begin ret_m++; return; end
        if (ill) return;
        if (op == 4'hF) begin
            ret_m++;
            e = '0;
            e.halted = 1'b1;
            for (int i = 0; i < 3; i++) cyc(rnd1(), rop(), rnd1(), e, "halt");
            chk("halt_retired", 32'(retired), 32'(16'(ret_m)));
            return;
        end
        e = '0;
        if (is_ls) begin
            e.alu_op = 2'b01;
            e.alu_src_b = 1'b1;
        end else if (is_br) begin
            e.alu_op   = 2'b10;
            e.pc_src   = 2'b01;
            e.pc_write = (op == 4'hA) ? z : !z;
        end else if (is_r) begin
            e.alu_src_b = (op == 4'h3);
        end
        cyc(rnd1(), rop(), is_br ? z : rnd1(), e, "exec");
        if (is_br) begin ret_m++; return; end
        if (is_ls) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0;
                e.mem_req   = 1'b1;
                e.iord      = 1'b1;
                e.mem_we    = (op == 4'h1);
                e.alu_op    = 2'b01;
                e.alu_src_b = 1'b1;
                cyc(i == mw, rop(), rnd1(), e, "mem");
            end
            if (op == 4'h1) begin ret_m++; return; end
        end
        e = '0;
        e.reg_write  = 1'b1;
        e.mem_to_reg = (op == 4'h0);
        cyc(rnd1(), rop(), rnd1(), e, "wb");
        ret_m++;
    endtask

    task automatic wait_irw(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ir_write) begin ok = 1'b1; return; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[11];
        ctl_t       e;
        bit         ok;
        int         lat, regw, pcw;
        logic [15:0] r0;
        int         fw, mw;
        logic [3:0] op;

        // op, zero, cycles between fetches, reg_write pulses, pc_write pulses, retire delta
        tbl[0]  = '{4'h2, 1'b0, 4, 1, 1, 1};
        tbl[1]  = '{4'h3, 1'b0, 4, 1, 1, 1};
        tbl[2]  = '{4'h0, 1'b0, 5, 1, 1, 1};
        tbl[3]  = '{4'h1, 1'b0, 4, 0, 1, 1};
        tbl[4]  = '{4'hA, 1'b1, 3, 0, 2, 1};
        tbl[5]  = '{4'hA, 1'b0, 3, 0, 1, 1};
        tbl[6]  = '{4'hB, 1'b1, 3, 0, 1, 1};
        tbl[7]  = '{4'hB, 1'b0, 3, 0, 2, 1};
        tbl[8]  = '{4'hC, 1'b0, 2, 0, 2, 1};
        tbl[9]  = '{4'hD, 1'b0, 2, 0, 1, 0};
        tbl[10] = '{4'h7, 1'b1, 4, 1, 1, 1};

        do_reset();

        // Zero-wait latency table: measure between consecutive instruction fetches.
        for (int t = 0; t < 11; t++) begin
            mem_ready    = 1'b1;
            zero         = tbl[t].z;
            mem_rdata_op = tbl[t].op;
            wait_irw(ok);
            chk("tbl_start", 32'(ok), 32'd1);
            r0   = retired;
            regw = 0;
            pcw  = int'(pc_write);
            lat  = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                lat++;
                if (ir_write) break;
                regw += int'(reg_write);
                pcw  += int'(pc_write);
            end
            chk($sformatf("tbl%0d_lat", t),  32'(lat),  32'(tbl[t].lat));
            chk($sformatf("tbl%0d_regw", t), 32'(regw), 32'(tbl[t].regw));
            chk($sformatf("tbl%0d_pcw", t),  32'(pcw),  32'(tbl[t].pcw));
            chk($sformatf("tbl%0d_ret", t),  32'(16'(retired - r0)), 32'(tbl[t].dret));
            @(posedge clk);
            #1;
        end

        // Randomized instruction stream with random memory waits.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            op = 4'($urandom_range(0, 14));
            fw = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
            run_instr(op, rnd1(), fw, mw);
        end
        run_instr(4'hD, 1'b0, 0, 0);
        run_instr(4'hF, 1'b0, 1, 0);

        // Directed: ADD from reset, LOAD with 3 wait cycles, BEQ/BNE with zero=1.
        do_reset();
        run_instr(4'h2, 1'b0, 0, 0);
        run_instr(4'h0, 1'b0, 0, 3);
        run_instr(4'hA, 1'b1, 0, 0);
        run_instr(4'hB, 1'b1, 0, 0);
        run_instr(4'hE, 1'b0, 0, 0);
        chk("retired_directed", 32'(retired), 32'd4);

        // Watchdog: no ready in FETCH for 15 cycles -> bus error and halt.
        do_reset();
        e = '0;
        e.mem_req = 1'b1;
        for (int i = 0; i < 15; i++) cyc(1'b0, rop(), rnd1(), e, "wd_wait");
        e = '0;
        e.halted = 1'b1;
        e.bus_error = 1'b1;
        for (int i = 0; i < 3; i++) cyc(rnd1(), rop(), rnd1(), e, "wd_halt");
        chk("wd_retired", 32'(retired), 32'd0);

        // Ready on the 15th request cycle wins, in FETCH and in MEM.
        do_reset();
        run_instr(4'h2, 1'b0, 14, 0);
        run_instr(4'h0, 1'b0, 0, 14);

        // Reset mid-MEM of a STORE drops the request asynchronously.
        e = '0;
        e.mem_req = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        cyc(1'b1, 4'h1, rnd1(), e, "st_fetch");
        cyc(rnd1(), rop(), rnd1(), ctl_t'('0), "st_decode");
        e = '0;
        e.alu_op = 2'b01;
        e.alu_src_b = 1'b1;
        cyc(rnd1(), rop(), rnd1(), e, "st_exec");
        mem_ready = 1'b0;
        #2;
        chk("st_mem_req_we", 32'({mem_req, mem_we, iord}), 32'b111);
        chk("st_pre_retired", 32'(retired), 32'd2);
        do_reset();
        run_instr(4'h1, 1'b0, 0, 0);
        chk("st_final_retired", 32'(retired), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
